axis_frame_source: RTL
======================

// Module: axis_frame_source
// PURPOSE
//   AXI-Stream master that sources test and operand frames into the stream coprocessors (FP_LUT S_AXIS side).
//   Software-side or bench logic pushes words into an internal FIFO through a simple write port.
//   On START, the block emits exactly FRAME_LEN words as one AXI-Stream frame, with TLAST on the final beat.
//   Used in-system as a DMA stand-in and as the reusable stimulus driver in coprocessor benches.
// PARAMETERS
//   DATA_WIDTH  32  width of WR_DATA and M_AXIS_TDATA
//   DEPTH       16  FIFO depth in words; power of 2, must be >= FRAME_LEN
//   FRAME_LEN   6   beats per frame; >= 1
// PORTS
//   ACLK           in   1             clock; all logic on rising edge
//   ARESET         in   1             synchronous, active-high reset
//   WR_EN          in   1             push WR_DATA into FIFO this cycle
//   WR_DATA        in   DATA_WIDTH    word to push
//   WR_FULL        out  1             FIFO holds DEPTH words
//   LEVEL          out  log2(DEPTH)+1 current FIFO occupancy
//   OVERFLOW       out  1             sticky: a write was dropped while full
//   START          in   1             request one frame
//   START_ERR      out  1             1-cycle pulse: START rejected
//   BUSY           out  1             frame in progress (state SEND)
//   FRAMES_SENT    out  16            count of completed frames, wraps at 2^16
//   M_AXIS_TVALID  out  1             stream valid
//   M_AXIS_TDATA   out  DATA_WIDTH    stream data
//   M_AXIS_TLAST   out  1             last beat of frame
//   M_AXIS_TREADY  in   1             downstream ready
// BEHAVIOUR
//   Reset (ARESET=1 at an edge):
//     - State goes to IDLE; FIFO pointers, LEVEL, beat counter and FRAMES_SENT are cleared.
//     - OVERFLOW, START_ERR, BUSY, TVALID and TLAST are all 0.
//     - Reset mid-frame aborts the frame: TVALID is 0 the cycle after; no TLAST is issued; FIFO contents are discarded.
//   FIFO:
//     - Write: WR_EN && !WR_FULL stores the word and increments wr_ptr.
//     - Pop: a pop occurs on every beat where M_AXIS_TVALID && M_AXIS_TREADY.
//     - Simultaneous push and pop leaves LEVEL unchanged; this is legal even when full, since the pop frees a slot in the same cycle.
//     - Overflow: WR_EN while full with no same-cycle pop drops the word and sets OVERFLOW.
//     - Pointers wrap modulo DEPTH.
//   FSM states:
//     - IDLE -> SEND when START && LEVEL >= FRAME_LEN; beat counter is cleared.
//     - START in IDLE with LEVEL < FRAME_LEN is rejected: START_ERR pulses next cycle and state stays IDLE.
//     - START while in SEND is ignored, with no error and no queueing.
//     - SEND -> IDLE on the handshake of the beat where beat == FRAME_LEN-1. FRAMES_SENT increments on that same edge.
//   Stream:
//     - M_AXIS_TVALID = (state == SEND), registered. The first beat is valid the cycle after START is accepted.
//     - M_AXIS_TDATA = mem[rd_ptr].
//     - M_AXIS_TLAST = SEND && beat == FRAME_LEN-1.
//     - Throughput is 1 beat/cycle while TREADY is high.
//     - While TVALID && !TREADY, TDATA and TLAST are held stable and no pop occurs.
//     - TVALID is never deasserted mid-frame except by reset.
//     - Writes arriving during SEND do not affect the current frame's data, because the frame words are already resident.
//   FRAME_LEN = 1: each accepted START produces a single beat with TLAST = 1.
//   BUSY = (state == SEND).
// TESTING
//   1. Push 1,200,61,1,400,21; pulse START with TREADY = 1.
//      -> Six consecutive beats with TDATA 1,200,61,1,400,21; TLAST only on 21; FRAMES_SENT = 1; LEVEL = 0.
//   2. Same frame with TREADY toggling 1,0,0,1,...
//      -> No beat is lost or duplicated; TDATA and TLAST are held during stalls; output order is preserved.
//   3. Push 5 words, then START.
//      -> START_ERR pulses; TVALID stays 0. Push a 6th word, then START: the frame is sent.
//   4. Push 17 words with DEPTH = 16.
//      -> WR_FULL = 1 after the 16th word; the 17th is dropped; OVERFLOW = 1.
//      -> Two back-to-back frames then drain the 12 oldest words in order.
//   5. Assert ARESET during beat 3 of a frame.
//      -> Next cycle: TVALID = 0, LEVEL = 0, BUSY = 0. A new push of 6 words plus START yields a clean frame.
//   6. While a frame is sending, write on every cycle and stall TREADY until full.
//      -> The simultaneous push+pop keeps LEVEL constant; the next frame contains the new words in order.

Source files
------------

// File: rtl/axis_frame_source.sv
// AXI-Stream frame source: words are queued through a write port and, on START,
// exactly FRAME_LEN of them leave as one frame with TLAST on the final beat.
module axis_frame_source #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FRAME_LEN  = 6
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic                        wr_full,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    input  logic                        start,
    output logic                        start_err,
    output logic                        busy,
    output logic [15:0]                 frames_sent,
    output logic                        m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_FRAME = LVL_W'(FRAME_LEN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [BEAT_W-1:0]      beat_r;
    logic [BEAT_W-1:0]      beat_s;
    logic                   reject_s;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [LVL_W-1:0]       level_r;
    logic [15:0]            frames_r;
    logic                   overflow_r;
    logic                   start_err_r;
    logic [DATA_WIDTH-1:0]  mem_r [DEPTH];

    logic                   full_s;
    logic                   pop_s;
    logic                   push_s;
    logic                   last_s;
    logic                   done_s;

    // FIFO handshake qualifiers; a pop in the same cycle frees the slot a full write needs
    always_comb begin
        full_s = (level_r == LVL_FULL);
        pop_s  = (state_r == ST_SEND) && m_axis_tready;
        push_s = wr_en && (!full_s || pop_s);
        last_s = (beat_r == LAST_BEAT);
        done_s = pop_s && last_s;
    end

    // Next-state and beat counter logic
    always_comb begin
        state_s  = state_r;
        beat_s   = beat_r;
        reject_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (level_r >= LVL_FRAME) begin
                        state_s = ST_SEND;
                        beat_s  = {BEAT_W{1'b0}};
                    end else begin
                        reject_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (pop_s) begin
                    if (last_s) begin
                        state_s = ST_IDLE;
                        beat_s  = {BEAT_W{1'b0}};
                    end else begin
                        beat_s = beat_r + BEAT_W'(1);
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // FSM state, beat counter and status registers
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            beat_r      <= {BEAT_W{1'b0}};
            frames_r    <= 16'd0;
            overflow_r  <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            beat_r      <= beat_s;
            start_err_r <= reject_s;
            if (done_s) begin
                frames_r <= frames_r + 16'd1;
            end
            if (wr_en && full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; pointer wrap is the natural modulo-DEPTH rollover
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents need no reset since the pointers define validity
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign wr_full       = full_s;
    assign level         = level_r;
    assign overflow      = overflow_r;
    assign start_err     = start_err_r;
    assign busy          = (state_r == ST_SEND);
    assign frames_sent   = frames_r;
    assign m_axis_tvalid = (state_r == ST_SEND);
    assign m_axis_tdata  = mem_r[rd_ptr_r];
    assign m_axis_tlast  = (state_r == ST_SEND) && last_s;

endmodule
